// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle RV32I datapath and its main control FSM.
// The datapath side uses the master modport; the controller uses the slave modport.
interface multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               zero;
    logic               pc_write;
    logic               adr_src;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         alu_control;
    logic [1:0]         imm_src;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, illegal, state
    );

    modport slave (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main control FSM for the multicycle RV32I datapath, with ALU decoder and sticky illegal-opcode flag.
// 2 to 5 cycles per instruction (FETCH to FETCH); no backpressure, zero is consumed combinationally in BEQ.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_ctrl_if.slave bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECR    = STATE_W'(6),
        ALUWB    = STATE_W'(7),
        EXECI    = STATE_W'(8),
        JAL      = STATE_W'(9),
        BEQ      = STATE_W'(10)
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_set_illegal;
    logic       w_pc_update;
    logic       w_branch;
    logic [1:0] w_alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | w_set_illegal;
        end
    end

    always_comb begin
        w_next         = FETCH;
        w_set_illegal  = 1'b0;
        w_pc_update    = 1'b0;
        w_branch       = 1'b0;
        w_alu_op       = 2'b00;
        bus.adr_src    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        case (r_state)
            FETCH: begin
                bus.ir_write   = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                w_pc_update    = 1'b1;
                w_next         = DECODE;
            end
            DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_RTYPE:          w_next = EXECR;
                    OP_ITYPE:          w_next = EXECI;
                    OP_JAL:            w_next = JAL;
                    OP_BEQ:            w_next = BEQ;
                    default: begin
                        w_next        = FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                w_next        = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.adr_src = 1'b1;
                w_next      = MEMWB;
            end
            MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            EXECR: begin
                bus.alu_src_a = 2'b10;
                w_alu_op      = 2'b10;
                w_next        = ALUWB;
            end
            EXECI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                w_alu_op      = 2'b10;
                w_next        = ALUWB;
            end
            ALUWB: begin
                bus.reg_write = 1'b1;
            end
            JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                w_pc_update   = 1'b1;
                w_next        = ALUWB;
            end
            BEQ: begin
                bus.alu_src_a = 2'b10;
                w_alu_op      = 2'b01;
                w_branch      = 1'b1;
            end
            default: w_next = FETCH;
        endcase
    end

    // op[5] separates R-type (sub allowed) from I-type, where funct7b5 is immediate data.
    always_comb begin
        bus.alu_control = 3'b000;
        case (w_alu_op)
            2'b01: bus.alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.alu_control = 3'b101;
                    3'b110:  bus.alu_control = 3'b011;
                    3'b111:  bus.alu_control = 3'b010;
                    default: bus.alu_control = 3'b000;
                endcase
            end
            default: bus.alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_STORE: bus.imm_src = 2'b01;
            OP_BEQ:   bus.imm_src = 2'b10;
            OP_JAL:   bus.imm_src = 2'b11;
            default:  bus.imm_src = 2'b00;
        endcase
    end

    assign bus.pc_write = w_pc_update | (w_branch & bus.zero);
    assign bus.illegal  = r_illegal;
    assign bus.state    = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed and randomized instruction streams checked cycle by cycle against a reference of the control spec.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   ill_model = 1'b0;

    multicycle_ctrl_if #(.STATE_W(4)) bus ();

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction class from the opcode: 0 lw,1 sw,2 R-ALU,3 I-ALU,4 jal,5 beq,6 illegal.
    function automatic int cls(input logic [6:0] op);
        case (op)
            7'h03:   return 0;
            7'h23:   return 1;
            7'h33:   return 2;
            7'h13:   return 3;
            7'h6F:   return 4;
            7'h63:   return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int path_len(input logic [6:0] op);
        int lens[7] = '{5, 4, 4, 4, 4, 3, 2};
        return lens[cls(op)];
    endfunction

    function automatic int path_st(input logic [6:0] op, input int k);
        int p[7][5] = '{'{0,1,2,3,4}, '{0,1,2,5,0}, '{0,1,6,7,0}, '{0,1,8,7,0},
                        '{0,1,9,7,0}, '{0,1,10,0,0}, '{0,1,0,0,0}};
        return p[cls(op)][k];
    endfunction

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b}
    function automatic logic [12:0] exp_ctl(input int st, input logic z);
        case (st)
            0:  return {5'b10010, 2'b10, 2'b00, 2'b10};
            1:  return {5'b00000, 2'b00, 2'b01, 2'b01};
            2:  return {5'b00000, 2'b00, 2'b10, 2'b01};
            3:  return {5'b01000, 2'b00, 2'b00, 2'b00};
            4:  return {5'b00001, 2'b01, 2'b00, 2'b00};
            5:  return {5'b01100, 2'b00, 2'b00, 2'b00};
            6:  return {5'b00000, 2'b00, 2'b10, 2'b00};
            7:  return {5'b00001, 2'b00, 2'b00, 2'b00};
            8:  return {5'b00000, 2'b00, 2'b10, 2'b01};
            9:  return {5'b10000, 2'b00, 2'b01, 2'b10};
            10: return {z, 4'b0000, 2'b00, 2'b10, 2'b00};
            default: return 13'd0;
        endcase
    endfunction

    // Only the execute steps of ALU instructions use funct3; branches subtract; everything else adds.
    function automatic logic [2:0] exp_alu(input int st, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7);
        if (st == 10) return 3'b001;
        if (st != 6 && st != 8) return 3'b000;
        case (f3)
            3'b000:  return (op == 7'h33 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        case (cls(op))
            1:       return 2'b01;
            4:       return 2'b10 + 2'b01;
            5:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Called just after a rising edge with the DUT in FETCH; returns just after the edge back into FETCH.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int zmode);
        int   st;
        logic z;
        logic [12:0] obs_ctl;
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        for (int k = 0; k < path_len(op); k++) begin
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            bus.zero = z;
            st = path_st(op, k);
            @(negedge clk);
            obs_ctl = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                       bus.result_src, bus.alu_src_a, bus.alu_src_b};
            chk($sformatf("%s state c%0d", name, k), 32'(bus.state), 32'(st));
            chk($sformatf("%s ctl c%0d", name, k), 32'(obs_ctl), 32'(exp_ctl(st, z)));
            chk($sformatf("%s alu c%0d", name, k), 32'(bus.alu_control), 32'(exp_alu(st, op, f3, f7)));
            chk($sformatf("%s imm c%0d", name, k), 32'(bus.imm_src), 32'(exp_imm(op)));
            chk($sformatf("%s illegal c%0d", name, k), 32'(bus.illegal), 32'(ill_model));
            @(posedge clk);
            #1;
        end
        if (cls(op) == 6) ill_model = 1'b1;
    endtask

    initial begin
        logic [6:0] ops[8] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h63, 7'h7F, 7'h00};
        logic [6:0] rop;
        bus.op       = 7'h00;
        bus.funct3   = 3'b000;
        bus.funct7b5 = 1'b0;
        bus.zero     = 1'b0;

        #2;
        chk("reset state", 32'(bus.state), 32'd0);
        chk("reset ir_write", 32'(bus.ir_write), 32'd1);
        chk("reset pc_write", 32'(bus.pc_write), 32'd1);
        chk("reset illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after release state", 32'(bus.state), 32'd1);
        @(posedge clk);
        #1;
        // The dummy op 0 counts as illegal from the DECODE cycle just passed.
        ill_model = 1'b1;
        rst_n = 1'b0;
        #1;
        ill_model = 1'b0;
        chk("rearm illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // That edge was the first after release; rewind by resetting again so runs start aligned.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        // Now just after an edge with the DUT in FETCH.
        run_instr("lw",   7'h03, 3'b010, 1'b0, 0);
        run_instr("sw",   7'h23, 3'b010, 1'b0, 0);
        run_instr("sub",  7'h33, 3'b000, 1'b1, 0);
        run_instr("addi", 7'h13, 3'b000, 1'b0, 0);
        run_instr("beqz1", 7'h63, 3'b000, 1'b0, 1);
        run_instr("beqz0", 7'h63, 3'b000, 1'b0, 0);
        run_instr("jal",  7'h6F, 3'b000, 1'b0, 0);
        run_instr("ill7f", 7'h7F, 3'b000, 1'b0, 0);
        run_instr("lw2",  7'h03, 3'b010, 1'b0, 0);

        for (int n = 0; n < 50; n++) begin
            rop = ops[$urandom_range(0, 7)];
            if (rop == 7'h00) rop = 7'($urandom);
            run_instr($sformatf("rnd%0d", n), rop, 3'($urandom), 1'($urandom), 2);
        end

        // Abort a load in MEMREAD with an asynchronous reset.
        bus.op = 7'h03;
        bus.funct3 = 3'b010;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre-abort state", 32'(bus.state), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        ill_model = 1'b0;
        chk("abort state", 32'(bus.state), 32'd0);
        chk("abort ir_write", 32'(bus.ir_write), 32'd1);
        chk("abort pc_write", 32'(bus.pc_write), 32'd1);
        chk("abort illegal", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #1;
        chk("held in reset", 32'(bus.state), 32'd0);
        rst_n = 1'b1;
        run_instr("lw-after", 7'h03, 3'b010, 1'b0, 0);
        run_instr("beq-after", 7'h63, 3'b000, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
